// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative divider.
// Optional remainder output is enabled by defining DIVIDER_REM_EN.
package divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    // Widest operand the sign-magnitude helper handles; DATA_LEN must stay below it.
    localparam int DIV_MAX_W = 64;

    localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

    // Caller sign-extends (or zero-extends) the operand; returns its magnitude.
    function automatic logic [DIV_MAX_W-1:0] abs_ext(input logic [DIV_MAX_W-1:0] x);
        return x[DIV_MAX_W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module div_step #(
    parameter int DATA_LEN = 32
) (
    input  logic [DATA_LEN-1:0] rem_i,
    input  logic                bit_i,
    input  logic [DATA_LEN:0]   dvs_i,
    output logic [DATA_LEN-1:0] rem_o,
    output logic                q_o
);

    logic [DATA_LEN:0] shifted;
    logic [DATA_LEN:0] diff;
    logic              unused_diff_msb;

    // The remainder stays below the divisor, so it always fits in DATA_LEN bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - dvs_i;
        q_o     = (shifted >= dvs_i);
        rem_o   = q_o ? diff[DATA_LEN-1:0] : shifted[DATA_LEN-1:0];
    end

    assign unused_diff_msb = diff[DATA_LEN];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider, one operation in flight, DATA_LEN+2 cycle latency.
// Define DIVIDER_REM_EN to get the signed-corrected remainder on the remain port.
module iter_divider
    import divider_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int CNT_W    = $clog2(DATA_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_signed,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] quotient,
`ifdef DIVIDER_REM_EN
    output logic [DATA_LEN-1:0] remain,
`endif
    output logic                div_zero
);

    div_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_LEN-1:0] dvd_q;     // dividend bits shift out the top, quotient bits shift in
    logic [DATA_LEN:0]   dvs_q;
    logic [DATA_LEN-1:0] prem_q;
    logic                neg_quo_q;
    logic                zero_q;
    logic [DATA_LEN-1:0] quo_q;
    logic                dz_q;
    logic                out_valid_q;
    logic                in_ready_q;
`ifdef DIVIDER_REM_EN
    logic                neg_rem_q;
    logic [DATA_LEN-1:0] a_q;
    logic [DATA_LEN-1:0] rem_q;
`endif

    logic [DIV_MAX_W-1:0] a_ext, b_ext, a_mag, b_mag;
    logic [DATA_LEN-1:0]  step_rem_d;
    logic                 step_q_d;
    logic                 unused_mag;

    always_comb begin
        a_ext = {{(DIV_MAX_W-DATA_LEN){in_signed & a[DATA_LEN-1]}}, a};
        b_ext = {{(DIV_MAX_W-DATA_LEN){in_signed & b[DATA_LEN-1]}}, b};
        a_mag = abs_ext(a_ext);
        b_mag = abs_ext(b_ext);
    end

    assign unused_mag = ^{a_mag[DIV_MAX_W-1:DATA_LEN], b_mag[DIV_MAX_W-1:DATA_LEN+1]};

    div_step #(.DATA_LEN(DATA_LEN)) u_step (
        .rem_i (prem_q),
        .bit_i (dvd_q[DATA_LEN-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem_d),
        .q_o   (step_q_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            neg_quo_q   <= 1'b0;
            zero_q      <= 1'b0;
            quo_q       <= '0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef DIVIDER_REM_EN
            neg_rem_q   <= 1'b0;
            a_q         <= '0;
            rem_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        dvd_q      <= a_mag[DATA_LEN-1:0];
                        dvs_q      <= b_mag[DATA_LEN:0];
                        prem_q     <= '0;
                        cnt_q      <= CNT_W'(DATA_LEN - 1);
                        neg_quo_q  <= in_signed & (a[DATA_LEN-1] ^ b[DATA_LEN-1]);
                        zero_q     <= (b == '0);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
`ifdef DIVIDER_REM_EN
                        neg_rem_q  <= in_signed & a[DATA_LEN-1];
                        a_q        <= a;
`endif
                    end
                end
                CALC: begin
                    prem_q <= step_rem_d;
                    dvd_q  <= {dvd_q[DATA_LEN-2:0], step_q_d};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0)
                        state_q <= FIX;
                end
                FIX: begin
                    // Divide-by-zero bypasses sign correction so quotient is all ones in both modes.
                    if (zero_q) begin
                        quo_q <= DIV_ZERO_Q[DATA_LEN-1:0];
`ifdef DIVIDER_REM_EN
                        rem_q <= a_q;
`endif
                    end else begin
                        quo_q <= neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
`ifdef DIVIDER_REM_EN
                        rem_q <= neg_rem_q ? (~prem_q + 1'b1) : prem_q;
`endif
                    end
                    dz_q    <= zero_q;
                    state_q <= DONE;
                end
                DONE: begin
                    // First DONE cycle only raises out_valid, giving the fixed DATA_LEN+2 latency.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign div_zero  = dz_q;
`ifdef DIVIDER_REM_EN
    assign remain    = rem_q;
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider (DATA_LEN=32); remainder checks follow DIVIDER_REM_EN.
module tb_iter_divider;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, in_signed, out_valid, out_ready, div_zero;
    logic [W-1:0] a, b, quotient;
`ifdef DIVIDER_REM_EN
    logic [W-1:0] remain;
`endif

    iter_divider #(.DATA_LEN(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
`ifdef DIVIDER_REM_EN
        .remain    (remain),
`endif
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    bit   lat_pend = 1'b0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   e;
        longint sx, sy;
        if (y == '0) begin
            e.q = '1; e.r = x; e.dz = 1'b1;
        end else if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            e.q = W'(sx / sy); e.r = W'(sx % sy); e.dz = 1'b0;
        end else begin
            e.q = x / y; e.r = x % y; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor runs on the falling edge; every wait in the bench goes through here.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reset) begin
            sb.delete();
            lat_pend = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cyc  = cyc;
                lat_pend = 1'b1;
            end
            // Accept is seen half a cycle before its edge, so DATA_LEN+2 edges read as +3.
            if (out_valid && lat_pend) begin
                chk("latency", 64'(cyc - acc_cyc), 64'(W + 3));
                lat_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", 64'(quotient), 64'(e.q));
`ifdef DIVIDER_REM_EN
                    chk("remain", 64'(remain), 64'(e.r));
`endif
                    chk("div_zero", 64'(div_zero), 64'(e.dz));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input exp_t e);
        int n = 0;
        while (!in_ready && n < 200) begin step(); n++; end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        sb.push_back(e);
        a = x; b = y; in_signed = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; in_signed = 1'($urandom);
    endtask

    task automatic drain(input int gap);
        int n = 0;
        out_ready = (gap == 0);
        while (!out_valid && n < 100) begin step(); n++; end
        if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
        repeat (gap) step();
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 10) begin step(); n++; end
        if (out_valid) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] x, y;
        logic         s;
        reset = 1'b1; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
`ifdef DIVIDER_REM_EN
        chk("rst_remain", 64'(remain), 64'd0);
`endif
        reset = 1'b0;
        step();

        issue(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, dz: 1'b0});
        drain(0);
        issue(-32'sd7, 32'd2, 1'b1, '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0});
        drain(0);
        issue(32'd7, -32'sd2, 1'b1, '{q: 32'hFFFF_FFFD, r: 32'd1, dz: 1'b0});
        drain(0);
        issue(32'h1234_5678, 32'd0, 1'b0, '{q: 32'hFFFF_FFFF, r: 32'h1234_5678, dz: 1'b1});
        drain(0);
        issue(32'h1234_5678, 32'd0, 1'b1, '{q: 32'hFFFF_FFFF, r: 32'h1234_5678, dz: 1'b1});
        drain(0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0});
        drain(0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '{q: 32'd0, r: 32'h8000_0000, dz: 1'b0});
        drain(0);
        issue(32'd0, 32'd5, 1'b1, '{q: 32'd0, r: 32'd0, dz: 1'b0});
        drain(0);

        // Backpressure: hold the result for 10 cycles while poking in_valid.
        out_ready = 1'b0;
        issue(32'd1000, 32'd10, 1'b0, '{q: 32'd100, r: 32'd0, dz: 1'b0});
        begin
            int n = 0;
            while (!out_valid && n < 100) begin step(); n++; end
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 32'd77; b = 32'd3;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_quotient", 64'(quotient), 64'd100);
`ifdef DIVIDER_REM_EN
            chk("bp_remain", 64'(remain), 64'd0);
`endif
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of CALC abandons the operation.
        issue(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, dz: 1'b0});
        repeat (10) step();
        reset = 1'b1;
        step();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_quotient", 64'(quotient), 64'd0);
        chk("midrst_div_zero", 64'(div_zero), 64'd0);
        reset = 1'b0;
        step();
        issue(32'd9, 32'd3, 1'b0, '{q: 32'd3, r: 32'd0, dz: 1'b0});
        drain(0);

        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 3)) step();
            s = 1'($urandom);
            x = pick();
            y = pick();
            issue(x, y, s, model(x, y, s));
            drain($urandom_range(0, 4));
        end

        repeat (5) step();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
